// File: rtl/lcd_de_receiver.sv
// lcd_de_receiver: DE-mode RGB sink recovering pixel coordinates, frame/line strobes and timing lock.
module lcd_de_receiver #(
  parameter int EXP_WIDTH  = 640,
  parameter int EXP_HEIGHT = 480,
  parameter int H_BLANK    = 160,
  parameter int VB_THRESH  = 800
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic        de_in,
  input  logic [7:0]  red_in,
  input  logic [7:0]  green_in,
  input  logic [7:0]  blue_in,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [23:0] pix_rgb,
  output logic        sof,
  output logic        eol,
  output logic        locked,
  output logic [10:0] meas_width,
  output logic [10:0] meas_hblank,
  output logic [9:0]  meas_height,
  output logic        line_err,
  output logic        frame_err
);
  if (VB_THRESH <= H_BLANK) begin : g_bad_thresh
    $error("VB_THRESH must exceed H_BLANK");
  end
  typedef enum logic [1:0] {SEARCH, VBLANK, LINE, HBLANK} state_t;
  state_t state, state_n;
  logic        de_q;
  logic [23:0] rgb_q;
  logic [10:0] low_run, hi_run, height;
  logic [9:0]  y, y_n;
  logic [1:0]  clean_cnt;
  logic        dirty, vb, pix, new_frame, fall, frame_end, inc, le_n, fe_n;
  // low_run/hi_run hold the run length before the current de_q sample, so a
  // rising edge sees the completed blank run and the first pixel sees x=0
  always_comb begin
    vb        = low_run >= 11'(VB_THRESH);
    fall      = state == LINE && !de_q;
    frame_end = state == HBLANK && vb;
    inc       = state == HBLANK && de_q && !vb;
    new_frame = de_q && (state == VBLANK || ((state == SEARCH || state == HBLANK) && vb));
    pix       = de_q && (state != SEARCH || vb);
    height    = {1'b0, y} + 11'd1;
    le_n      = fall && hi_run != 11'(EXP_WIDTH);
    fe_n      = frame_end && height != 11'(EXP_HEIGHT);
    y_n       = new_frame ? 10'd0 : (inc && y != 10'd1023) ? y + 10'd1 : y;
    state_n   = pix ? LINE : fall ? HBLANK :
                (vb && (state == SEARCH || state == HBLANK)) ? VBLANK : state;
  end
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state       <= SEARCH;
      de_q        <= 1'b0;
      rgb_q       <= '0;
      low_run     <= '0;
      hi_run      <= '0;
      y           <= '0;
      clean_cnt   <= '0;
      dirty       <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      sof         <= 1'b0;
      eol         <= 1'b0;
      locked      <= 1'b0;
      meas_width  <= '0;
      meas_hblank <= '0;
      meas_height <= '0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state     <= state_n;
      de_q      <= de_in;
      rgb_q     <= {red_in, green_in, blue_in};
      low_run   <= de_q ? 11'd0 : (&low_run ? low_run : low_run + 11'd1);
      hi_run    <= de_q ? (&hi_run ? hi_run : hi_run + 11'd1) : 11'd0;
      y         <= y_n;
      pix_valid <= pix;
      pix_x     <= pix ? (hi_run[10] ? 10'd1023 : hi_run[9:0]) : 10'd0;
      pix_y     <= pix ? y_n : 10'd0;
      pix_rgb   <= pix ? rgb_q : 24'd0;
      sof       <= new_frame;
      eol       <= pix && !de_in;
      line_err  <= le_n;
      frame_err <= fe_n;
      if (fall) meas_width <= hi_run;
      if (inc) meas_hblank <= low_run;
      if (frame_end) meas_height <= height[9:0];
      if (frame_end) dirty <= 1'b0;
      else if (le_n) dirty <= 1'b1;
      if (le_n || fe_n) begin
        locked    <= 1'b0;
        clean_cnt <= 2'd0;
      end else if (frame_end) begin
        clean_cnt <= dirty ? 2'd0 : {clean_cnt[0], 1'b1};
        locked    <= !dirty && clean_cnt[0];
      end
    end
  end
endmodule

// File: tb/tb_lcd_de_receiver.sv
// tb_lcd_de_receiver: scoreboard bench driving directed DE frames into lcd_de_receiver.
module tb_lcd_de_receiver;
  localparam int W = 120, H = 8, HB = 10, VB = 40, VBL = 60;
  logic        pixel_clk, rst, de_in;
  logic [7:0]  red_in, green_in, blue_in;
  logic        pix_valid, sof, eol, locked, line_err, frame_err;
  logic [9:0]  pix_x, pix_y, meas_height;
  logic [23:0] pix_rgb;
  logic [10:0] meas_width, meas_hblank;
  typedef struct { int x; int y; int rgb; bit sof; bit eol; int t; } pix_t;
  typedef struct { bit le; bit fe; int val; } err_t;
  pix_t pq[$];
  err_t eq[$];
  pix_t p;
  err_t e;
  int n_vec = 0, n_bad = 0, cyc_n = 0, seen = 0;

  lcd_de_receiver #(.EXP_WIDTH(W), .EXP_HEIGHT(H), .H_BLANK(HB), .VB_THRESH(VB)) dut (
    .pixel_clk(pixel_clk), .rst(rst), .de_in(de_in),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .sof(sof), .eol(eol), .locked(locked),
    .meas_width(meas_width), .meas_hblank(meas_hblank), .meas_height(meas_height),
    .line_err(line_err), .frame_err(frame_err));

  initial begin
    pixel_clk = 1'b0;
    forever #5 pixel_clk = ~pixel_clk;
  end
  always @(posedge pixel_clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc_n);
    end
  endtask

  always @(negedge pixel_clk) begin
    if (pix_valid) begin
      if (pq.size() == 0) chk("pix_unexpected", pq.size(), 1);
      else begin
        p = pq.pop_front();
        chk("pix_x", pix_x, p.x);
        chk("pix_y", pix_y, p.y);
        chk("pix_rgb", pix_rgb, p.rgb);
        chk("pix_sof", sof, p.sof);
        chk("pix_eol", eol, p.eol);
        chk("pix_latency", cyc_n, p.t);
      end
      if (pix_x == 10'd100 && pix_y == 10'd5) begin
        seen++;
        chk("rgb_x100_y5", pix_rgb, 24'h6405A5);
      end
    end else if (sof || eol) chk("strobe_no_valid", {sof, eol}, 0);
    if (line_err || frame_err) begin
      if (eq.size() == 0) chk("err_unexpected", eq.size(), 1);
      else begin
        e = eq.pop_front();
        chk("line_err", line_err, e.le);
        chk("frame_err", frame_err, e.fe);
        chk("err_meas", e.le ? meas_width : meas_height, e.val);
        chk("locked_on_err", locked, 0);
      end
    end
  end

  task automatic drive(input bit de, input logic [23:0] c);
    @(negedge pixel_clk);
    de_in = de;
    {red_in, green_in, blue_in} = c;
  endtask

  task automatic low(input int n);
    repeat (n) drive(1'b0, 24'd0);
  endtask

  // trk: number of leading pixels of the line expected at the outputs
  task automatic line(input int w, input int y, input int trk, input bit first);
    for (int x = 0; x < w; x++) begin
      logic [23:0] c;
      c = {x[7:0], y[7:0], 8'hA5};
      drive(1'b1, c);
      if (x < trk) pq.push_back('{x > 1023 ? 1023 : x, y, int'(c), first && x == 0, x == w - 1, cyc_n + 2});
    end
  endtask

  task automatic frame(input int n, input int bad_line, input int bad_w, input bit trk);
    for (int l = 0; l < n; l++) begin
      int w;
      w = (l == bad_line) ? bad_w : W;
      line(w, l, trk ? w : 0, trk && l == 0);
      if (trk && w != W) eq.push_back('{1'b1, 1'b0, w > 2047 ? 2047 : w});
      if (l < n - 1) low(HB);
    end
    if (trk && n != H) eq.push_back('{1'b0, 1'b1, n});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pix_valid"}, pix_valid, 0);
    chk({tag, "_sof_eol"}, {sof, eol}, 0);
    chk({tag, "_pix_xy"}, {pix_x, pix_y}, 0);
    chk({tag, "_pix_rgb"}, pix_rgb, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_meas_width"}, meas_width, 0);
    chk({tag, "_meas_hblank"}, meas_hblank, 0);
    chk({tag, "_meas_height"}, meas_height, 0);
    chk({tag, "_errs"}, {line_err, frame_err}, 0);
  endtask

  initial begin
    rst = 1'b1;
    de_in = 1'b0;
    {red_in, green_in, blue_in} = 24'd0;
    repeat (3) @(negedge pixel_clk);
    chk_zero("reset");
    rst = 1'b0;
    frame(H, -1, 0, 1'b0); low(VBL);
    chk("locked_search", locked, 0);
    frame(H, -1, 0, 1'b1); low(VBL);
    chk("locked_after_1", locked, 0);
    chk("meas_width", meas_width, W);
    chk("meas_hblank", meas_hblank, HB);
    chk("meas_height", meas_height, H);
    frame(H, -1, 0, 1'b1); low(VBL);
    chk("locked_after_2", locked, 1);
    frame(H, 3, W - 1, 1'b1); low(VBL);
    chk("locked_bad_line", locked, 0);
    frame(H, -1, 0, 1'b1); low(VBL);
    chk("locked_relock_1", locked, 0);
    frame(H, -1, 0, 1'b1); low(VBL);
    chk("locked_relock_2", locked, 1);
    frame(H - 1, -1, 0, 1'b1); low(VBL);
    chk("locked_short_frame", locked, 0);
    chk("meas_height_short", meas_height, H - 1);
    line(W, 0, W, 1'b1); low(HB);
    line(W, 1, W, 1'b0); low(VB - 1);
    line(W, 2, W, 1'b0);
    eq.push_back('{1'b0, 1'b1, 3});
    low(VB);
    line(W, 0, W, 1'b1);
    chk("meas_hblank_vb_minus1", meas_hblank, VB - 1);
    chk("meas_height_vb_exact", meas_height, 3);
    for (int l = 1; l < H; l++) begin
      low(HB);
      line(W, l, W, 1'b0);
    end
    low(VBL);
    frame(H, 2, 2100, 1'b1); low(VBL);
    chk("meas_width_sat_frame", meas_width, W);
    line(W, 0, W, 1'b1); low(HB);
    line(W, 1, W, 1'b0); low(HB);
    line(51, 2, 50, 1'b0);
    @(negedge pixel_clk);
    #2 rst = 1'b1;
    @(negedge pixel_clk);
    chk_zero("midline_reset");
    @(negedge pixel_clk);
    rst = 1'b0;
    line(W - 52, 2, 0, 1'b0);
    for (int l = 3; l < H; l++) begin
      low(HB);
      line(W, l, 0, 1'b0);
    end
    low(VBL);
    frame(H, -1, 0, 1'b1); low(VBL);
    chk("locked_after_reset_frame", locked, 0);
    chk("meas_height_after_reset", meas_height, H);
    repeat (5) @(negedge pixel_clk);
    chk("pix_queue_left", pq.size(), 0);
    chk("err_queue_left", eq.size(), 0);
    chk("seen_x100_y5", seen > 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
